// File: rtl/arb_mux2_pkg.sv
// arb_mux2 shared constants: source indices and arbiter reset state.
// Used by arb2_pick and arb_mux2.
package arb_mux2_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // B counts as the last winner so the first tie goes to A
  localparam logic LAST_GRANT_RST = SRC_B;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } grant_e;

  function automatic logic grant_idx(input logic [1:0] g);
    return g[1] ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/arb2_pick.sv
// Two-request tie-break: one-hot grant, bit0 = A, bit1 = B.
// ARB_MUX2_RR_EN selects round-robin ties; otherwise A always wins.
module arb2_pick
  import arb_mux2_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifndef ARB_MUX2_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // pick at most one requester
  always_comb begin
    grant = GNT_NONE;
    unique case (1'b1)
      (req_a && !req_b): grant = GNT_A;
      (!req_a && req_b): grant = GNT_B;
      (req_a && req_b): begin
`ifdef ARB_MUX2_RR_EN
        grant = (last_grant == SRC_A) ? GNT_B : GNT_A;
`else
        grant = GNT_A;
`endif
      end
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/arb_mux2.sv
// Two-source arbiter feeding one registered output word and its select.
// Tie policy set by ARB_MUX2_RR_EN (round-robin) or fixed A priority.
module arb_mux2
  import arb_mux2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  output logic             sel,
  input  logic             y_ready
);

  logic             load;
  logic             req_a;
  logic             req_b;
  logic             last_grant;
  logic [1:0]       grant;
  logic             xfer;
  logic             win_idx;
  logic [WIDTH-1:0] win_data;

  assign load  = !y_valid || y_ready;
  assign req_a = a_valid && load && !rst;
  assign req_b = b_valid && load && !rst;

  arb2_pick u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign a_ready = grant[0];
  assign b_ready = grant[1];
  assign xfer    = a_ready || b_ready;

  // winner word and index for the output register
  always_comb begin
    win_idx  = grant_idx(grant);
    win_data = (win_idx == SRC_B) ? b_data : a_data;
  end

  // output register: load on transfer, empty on pop, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid    <= 1'b0;
      y          <= '0;
      sel        <= SRC_A;
      last_grant <= LAST_GRANT_RST;
    end else if (xfer) begin
      y_valid    <= 1'b1;
      y          <= win_data;
      sel        <= win_idx;
      last_grant <= win_idx;
    end else if (y_ready) begin
      y_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux2.sv
// Scoreboard bench for arb_mux2: directed cases plus random traffic.
// Expected words come from a one-slot queue model of the output register.
module tb_arb_mux2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0;
  logic [W-1:0] a_data = '0;
  logic         a_ready;
  logic         b_valid = 1'b0;
  logic [W-1:0] b_data = '0;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y;
  logic         sel;
  logic         y_ready = 1'b0;

  arb_mux2 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y       (y),
    .sel     (sel),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  bit           pend = 0;
  bit           mlast = 1'b1;
  logic [W-1:0] last_y = '0;
  logic         last_sel = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // one clock of stimulus; the model predicts readies and the winner
  task automatic cycle(input bit av, input logic [W-1:0] ad,
                       input bit bv, input logic [W-1:0] bd,
                       input bit yr);
    bit   ld;
    bit   ea;
    bit   eb;
    exp_t e;
    @(posedge clk);
    #1;
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    y_ready = yr;
    #1;
    ld = (q.size() == 0) || yr;
    ea = 0;
    eb = 0;
    if (ld && av && bv) begin
`ifdef ARB_MUX2_RR_EN
      if (mlast) ea = 1; else eb = 1;
`else
      ea = 1;
`endif
    end else if (ld) begin
      ea = av;
      eb = bv;
    end
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    pend = ea || eb;
    if (pend) begin
      e.d = ea ? ad : bd;
      e.s = eb;
      q.push_back(e);
      mlast = eb;
    end
  endtask

  task automatic do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    q.delete();
    pend = 0;
    mlast = 1'b1;
    last_y = '0;
    last_sel = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", a_ready || b_ready, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
  endtask

  // monitor: compare the presented word and retire it on a pop
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = q.size() - (pend ? 1 : 0);
      chk("y_valid", y_valid, n > 0);
      if (y_valid && n > 0) begin
        chk("y", y, q[0].d);
        chk("sel", sel, q[0].s);
        if (y_ready) begin
          last_y = q[0].d;
          last_sel = q[0].s;
          void'(q.pop_front());
        end
      end else if (!y_valid) begin
        chk("y_hold", y, last_y);
        chk("sel_hold", sel, last_sel);
      end
    end
  end

  initial begin
    #2;
    do_reset();

    cycle(1, 8'h3C, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    for (int i = 0; i < 4; i++) cycle(1, 8'h11, 1, 8'h22, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    cycle(1, 8'hA5, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h11, 1, 8'h22, 0);
    cycle(1, 8'h11, 1, 8'h22, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    for (int i = 1; i <= 5; i++) cycle(0, 8'h00, 1, W'(i), 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    cycle(0, 8'h00, 1, 8'h77, 1);
    cycle(1, 8'h11, 1, 8'h22, 0);
    cycle(1, 8'h11, 1, 8'h22, 0);
    #2;
    do_reset();
    cycle(1, 8'h5A, 1, 8'hC3, 1);
    cycle(1, 8'h5B, 1, 8'hC4, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, W'($urandom),
            $urandom_range(0, 1) == 1, W'($urandom),
            $urandom_range(0, 3) != 0);

    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_mux2.md
ARB_MUX2 -- requirements
Module: arb_mux2

Interface
REQ-001 Parameter WIDTH, default 8, data width of each input and the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_valid  input  1  source A has a word.
REQ-005 a_data  input  WIDTH  source A word.
REQ-006 a_ready  output  1  source A word accepted this cycle.
REQ-007 b_valid  input  1  source B has a word.
REQ-008 b_data  input  WIDTH  source B word.
REQ-009 b_ready  output  1  source B word accepted this cycle.
REQ-010 y_valid  output  1  output register holds a word.
REQ-011 y  output  WIDTH  registered selected word.
REQ-012 sel  output  1  registered source of y (0 = A, 1 = B); drives the downstream 2-to-1 mux select.
REQ-013 y_ready  input  1  consumer takes y this cycle.

Function
REQ-014 Transfer on a side SHALL occur when that side's valid and ready are both 1 at a rising edge.
REQ-015 The block SHALL compute load = !y_valid || y_ready; a_ready and b_ready SHALL be 0 whenever load is 0.
REQ-016 With load = 1 and exactly one input valid, that input's ready SHALL be 1 and the other's ready 0.
REQ-017 With load = 1 and both valid, exactly one ready SHALL be 1, chosen per REQ-024/025; never both.
REQ-018 On a transfer, y SHALL take the winner's data, sel the winner's index, y_valid = 1 at the next edge (latency 1 cycle).
REQ-019 On y_ready = 1 with no new transfer, y_valid SHALL go 0 next edge; y and sel SHALL hold their last values.
REQ-020 While y_valid = 1 and y_ready = 0, y, sel and y_valid SHALL hold unchanged (stall).
REQ-021 Simultaneous output pop and input transfer SHALL leave y_valid = 1 with the new word (full throughput: one word per cycle).
REQ-022 a_ready/b_ready SHALL depend combinationally on valids, y_ready and state only; readies SHALL NOT depend on a_data/b_data.
REQ-023 A state register last_grant (1 bit) SHALL record the index of the most recent transfer winner; it SHALL update only on a transfer.

Reset
REQ-026 Asserting rst SHALL immediately force y_valid = 0, sel = 0, y = 0, last_grant = 1 (so A wins first tie); a_ready/b_ready SHALL be 0 while rst is 1.
REQ-027 Reset asserted mid-stall SHALL discard the held word; first post-reset tie SHALL grant A.

Configuration
REQ-024 With macro ARB_MUX2_RR_EN defined, ties SHALL grant the input not equal to last_grant (round-robin; strict alternation under continuous contention).
REQ-025 Without ARB_MUX2_RR_EN, ties SHALL always grant A (fixed priority); last_grant SHALL still be maintained but SHALL NOT affect arbitration.

Structure
REQ-028 A shared package arb_mux2_pkg SHALL hold the source-index constants SRC_A = 0, SRC_B = 1 and the reset value of last_grant.
REQ-029 The tie-break logic SHALL be a separate sub-module arb2_pick (inputs: two requests, last_grant; output: one-hot grant); datapath register stays in arb_mux2.

Verification
REQ-030 Reset: rst=1 mid-stall with y_valid=1 -> y_valid=0, sel=0, y=0 immediately; readies 0 during reset.
REQ-031 Single source: a_valid=1, a_data=8'h3C, b_valid=0, y_ready=1 -> a_ready=1; next cycle y=8'h3C, sel=0, y_valid=1.
REQ-032 Contention, RR build: a_data=8'h11, b_data=8'h22, both valid 4 cycles, y_ready=1 -> y sequence 11,22,11,22, sel 0,1,0,1; fixed build -> 11,11,11,11, b_ready never 1.
REQ-033 Back-pressure: y holding 8'hA5, y_ready=0 for 3 cycles with both inputs valid -> y, sel, y_valid unchanged, a_ready=b_ready=0; y_ready=1 -> next winner loaded next edge.
REQ-034 Throughput: B alone valid with data 1..5 each cycle, y_ready=1 -> y=1..5 on consecutive cycles, sel=1, no bubbles.
REQ-035 Drain: single word loaded, then no valids with y_ready=1 -> y_valid drops to 0 next edge; y and sel keep last values.
